// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer. Digits borrow downward through a mod-10/mod-(MAX_TENS+1)
// chain on each 1 Hz tick while running; reaching 00:00 pulses done and latches alarm.
module countdown_timer #(
  parameter int MAX_TENS = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        start,
  input  logic        stop,
  output logic [3:0]  sec_u,
  output logic [3:0]  sec_t,
  output logic [3:0]  min_u,
  output logic [3:0]  min_t,
  output logic        running,
  output logic        done,
  output logic        alarm
);

  localparam logic [3:0] TENS_MAX  = 4'(MAX_TENS);
  localparam logic [3:0] UNITS_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] digits_q, digits_d;   // {min_t, min_u, sec_t, sec_u}
  logic        running_q, running_d;
  logic        done_q, done_d;
  logic        alarm_q, alarm_d;

  logic [15:0] load_sat;
  logic [15:0] dec_digits;
  logic        su_borrow, st_borrow, mu_borrow;
  logic        cur_zero, dec_zero;

  function automatic logic [3:0] sat_digit(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

  // A digit at zero wraps to its maximum and raises a borrow into the next digit.
  function automatic logic [3:0] dec_digit(input logic [3:0] d, input logic [3:0] max,
                                           input logic en);
    if (!en)
      return d;
    else if (d == 4'd0)
      return max;
    else
      return d - 4'd1;
  endfunction

  function automatic logic borrow_out(input logic [3:0] d, input logic en);
    return en && (d == 4'd0);
  endfunction

  assign load_sat = {sat_digit(load_value[15:12], TENS_MAX),
                     sat_digit(load_value[11:8],  UNITS_MAX),
                     sat_digit(load_value[7:4],   TENS_MAX),
                     sat_digit(load_value[3:0],   UNITS_MAX)};

  assign su_borrow = borrow_out(digits_q[3:0],  1'b1);
  assign st_borrow = borrow_out(digits_q[7:4],  su_borrow);
  assign mu_borrow = borrow_out(digits_q[11:8], st_borrow);

  assign dec_digits = {dec_digit(digits_q[15:12], TENS_MAX,  mu_borrow),
                       dec_digit(digits_q[11:8],  UNITS_MAX, st_borrow),
                       dec_digit(digits_q[7:4],   TENS_MAX,  su_borrow),
                       dec_digit(digits_q[3:0],   UNITS_MAX, 1'b1)};

  assign cur_zero = (digits_q == 16'h0000);
  assign dec_zero = (dec_digits == 16'h0000);

  // Command priority: load, then stop, then start, then tick.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    done_d   = 1'b0;

    if (load) begin
      digits_d = load_sat;
      state_d  = IDLE;
    end else if (stop) begin
      if (state_q == RUN)
        state_d = PAUSED;
      else if (state_q == EXPIRED)
        state_d = IDLE;
    end else if (start && ((state_q == IDLE) || (state_q == PAUSED))) begin
      if (!cur_zero)
        state_d = RUN;
    end else if (tick && (state_q == RUN)) begin
      digits_d = dec_digits;
      if (dec_zero) begin
        done_d  = 1'b1;
        state_d = EXPIRED;
      end
    end

    running_d = (state_d == RUN);
    alarm_d   = (state_d == EXPIRED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      digits_q  <= 16'h0000;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      running_q <= running_d;
      done_q    <= done_d;
      alarm_q   <= alarm_d;
    end
  end

  assign min_t   = digits_q[15:12];
  assign min_u   = digits_q[11:8];
  assign sec_t   = digits_q[7:4];
  assign sec_u   = digits_q[3:0];
  assign running = running_q;
  assign done    = done_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: each task drives one scenario and checks
// {digits, running, done, alarm} against hand-computed values.
module tb_countdown_timer;

  logic        clk;
  logic        reset_n;
  logic        tick;
  logic        load;
  logic [15:0] load_value;
  logic        start;
  logic        stop;
  logic [3:0]  sec_u, sec_t, min_u, min_t;
  logic        running, done, alarm;
  logic [18:0] obs;

  int vecs = 0;
  int miss = 0;

  countdown_timer #(.MAX_TENS(5)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .stop       (stop),
    .sec_u      (sec_u),
    .sec_t      (sec_t),
    .min_u      (min_u),
    .min_t      (min_t),
    .running    (running),
    .done       (done),
    .alarm      (alarm)
  );

  // obs = {min_t, min_u, sec_t, sec_u, running, done, alarm}
  assign obs = {min_t, min_u, sec_t, sec_u, running, done, alarm};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge: holds inputs across one rising edge, returns at the next falling edge.
  task automatic drive(input logic l, input logic [15:0] lv, input logic s,
                       input logic p, input logic t);
    load       = l;
    load_value = lv;
    start      = s;
    stop       = p;
    tick       = t;
    @(negedge clk);
    load  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    tick  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    vecs++;
    if (obs !== {16'h0000, 3'b000}) begin
      $display("FAIL reset_state got=%h exp=%h", obs, {16'h0000, 3'b000});
      miss++;
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_expire();
    drive(1, 16'h0003, 0, 0, 0);
    vecs++;
    if (obs !== {16'h0003, 3'b000}) begin
      $display("FAIL t1_load got=%h exp=%h", obs, {16'h0003, 3'b000}); miss++;
    end
    drive(0, 16'h0, 1, 0, 0);
    vecs++;
    if (obs !== {16'h0003, 3'b100}) begin
      $display("FAIL t1_start got=%h exp=%h", obs, {16'h0003, 3'b100}); miss++;
    end
    drive(0, 16'h0, 0, 0, 1);
    vecs++;
    if (obs !== {16'h0002, 3'b100}) begin
      $display("FAIL t1_tick1 got=%h exp=%h", obs, {16'h0002, 3'b100}); miss++;
    end
    drive(0, 16'h0, 0, 0, 1);
    vecs++;
    if (obs !== {16'h0001, 3'b100}) begin
      $display("FAIL t1_tick2 got=%h exp=%h", obs, {16'h0001, 3'b100}); miss++;
    end
    drive(0, 16'h0, 0, 0, 1);
    vecs++;
    if (obs !== {16'h0000, 3'b011}) begin
      $display("FAIL t1_tick3_done got=%h exp=%h", obs, {16'h0000, 3'b011}); miss++;
    end
    drive(0, 16'h0, 0, 0, 0);
    vecs++;
    if (obs !== {16'h0000, 3'b001}) begin
      $display("FAIL t1_done_one_cycle got=%h exp=%h", obs, {16'h0000, 3'b001}); miss++;
    end
    drive(0, 16'h0, 0, 0, 1);
    vecs++;
    if (obs !== {16'h0000, 3'b001}) begin
      $display("FAIL t1_expired_ignores_tick got=%h exp=%h", obs, {16'h0000, 3'b001}); miss++;
    end
  endtask

  task automatic test_borrow_chain();
    drive(1, 16'h1000, 0, 0, 0);
    vecs++;
    if (obs !== {16'h1000, 3'b000}) begin
      $display("FAIL t2_load_clears_alarm got=%h exp=%h", obs, {16'h1000, 3'b000}); miss++;
    end
    drive(0, 16'h0, 1, 0, 0);
    drive(0, 16'h0, 0, 0, 1);
    vecs++;
    if (obs !== {16'h0959, 3'b100}) begin
      $display("FAIL t2_full_borrow got=%h exp=%h", obs, {16'h0959, 3'b100}); miss++;
    end
  endtask

  task automatic test_pause_resume();
    drive(1, 16'h0105, 0, 0, 0);
    drive(0, 16'h0, 1, 0, 0);
    drive(0, 16'h0, 0, 0, 1);
    vecs++;
    if (obs !== {16'h0104, 3'b100}) begin
      $display("FAIL t3_tick1 got=%h exp=%h", obs, {16'h0104, 3'b100}); miss++;
    end
    drive(0, 16'h0, 0, 0, 1);
    drive(0, 16'h0, 0, 1, 0);
    vecs++;
    if (obs !== {16'h0103, 3'b000}) begin
      $display("FAIL t3_stop got=%h exp=%h", obs, {16'h0103, 3'b000}); miss++;
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 16'h0, 0, 0, 1);
      vecs++;
      if (obs !== {16'h0103, 3'b000}) begin
        $display("FAIL t3_paused_tick%0d got=%h exp=%h", i, obs, {16'h0103, 3'b000}); miss++;
      end
    end
    drive(0, 16'h0, 1, 0, 0);
    vecs++;
    if (obs !== {16'h0103, 3'b100}) begin
      $display("FAIL t3_resume got=%h exp=%h", obs, {16'h0103, 3'b100}); miss++;
    end
    drive(0, 16'h0, 0, 0, 1);
    vecs++;
    if (obs !== {16'h0102, 3'b100}) begin
      $display("FAIL t3_resume_tick got=%h exp=%h", obs, {16'h0102, 3'b100}); miss++;
    end
  endtask

  task automatic test_saturate_and_zero_start();
    drive(1, 16'hFA7C, 0, 0, 0);
    vecs++;
    if (obs !== {16'h5959, 3'b000}) begin
      $display("FAIL t4_saturate got=%h exp=%h", obs, {16'h5959, 3'b000}); miss++;
    end
    drive(1, 16'h0000, 0, 0, 0);
    drive(0, 16'h0, 1, 0, 0);
    vecs++;
    if (obs !== {16'h0000, 3'b000}) begin
      $display("FAIL t4_start_at_zero got=%h exp=%h", obs, {16'h0000, 3'b000}); miss++;
    end
  endtask

  task automatic test_priority();
    drive(1, 16'h0010, 0, 0, 0);
    drive(0, 16'h0, 1, 0, 0);
    drive(1, 16'h0030, 0, 0, 1);
    vecs++;
    if (obs !== {16'h0030, 3'b000}) begin
      $display("FAIL t5_load_over_tick got=%h exp=%h", obs, {16'h0030, 3'b000}); miss++;
    end
    drive(0, 16'h0, 1, 0, 1);
    vecs++;
    if (obs !== {16'h0030, 3'b100}) begin
      $display("FAIL t5_start_tick_idle got=%h exp=%h", obs, {16'h0030, 3'b100}); miss++;
    end
    drive(0, 16'h0, 1, 1, 1);
    vecs++;
    if (obs !== {16'h0030, 3'b000}) begin
      $display("FAIL t5_stop_over_start got=%h exp=%h", obs, {16'h0030, 3'b000}); miss++;
    end
    drive(1, 16'h0001, 0, 0, 0);
    drive(0, 16'h0, 1, 0, 0);
    drive(0, 16'h0, 0, 0, 1);
    vecs++;
    if (obs !== {16'h0000, 3'b011}) begin
      $display("FAIL t5_expire got=%h exp=%h", obs, {16'h0000, 3'b011}); miss++;
    end
    drive(0, 16'h0, 0, 1, 0);
    vecs++;
    if (obs !== {16'h0000, 3'b000}) begin
      $display("FAIL t5_stop_clears_alarm got=%h exp=%h", obs, {16'h0000, 3'b000}); miss++;
    end
    drive(0, 16'h0, 1, 0, 0);
    vecs++;
    if (obs !== {16'h0000, 3'b000}) begin
      $display("FAIL t5_start_after_clear got=%h exp=%h", obs, {16'h0000, 3'b000}); miss++;
    end
  endtask

  task automatic test_async_reset();
    drive(1, 16'h0030, 0, 0, 0);
    drive(0, 16'h0, 1, 0, 0);
    drive(0, 16'h0, 0, 0, 1);
    vecs++;
    if (obs !== {16'h0029, 3'b100}) begin
      $display("FAIL t6_pre_reset got=%h exp=%h", obs, {16'h0029, 3'b100}); miss++;
    end
    #2 reset_n = 1'b0;
    #1;
    vecs++;
    if (obs !== {16'h0000, 3'b000}) begin
      $display("FAIL t6_async_clear got=%h exp=%h", obs, {16'h0000, 3'b000}); miss++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    drive(0, 16'h0, 0, 0, 1);
    vecs++;
    if (obs !== {16'h0000, 3'b000}) begin
      $display("FAIL t6_tick_after_reset got=%h exp=%h", obs, {16'h0000, 3'b000}); miss++;
    end
    drive(1, 16'h0002, 0, 0, 0);
    drive(0, 16'h0, 1, 0, 0);
    drive(0, 16'h0, 0, 0, 1);
    vecs++;
    if (obs !== {16'h0001, 3'b100}) begin
      $display("FAIL t6_run_after_reset got=%h exp=%h", obs, {16'h0001, 3'b100}); miss++;
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    tick       = 1'b0;
    load       = 1'b0;
    load_value = 16'h0000;
    start      = 1'b0;
    stop       = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_expire();
    test_borrow_chain();
    test_pause_resume();
    test_saturate_and_zero_start();
    test_priority();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
